// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, types and the write-resolution helper for
// the multi-port register file.
//
// rf_resolve_write() answers "does any enabled write port target addr this
// cycle, and if so with which data?". The write path and the read bypass
// both use it, so the two paths always agree on which port wins.
//
// The helper works on vectors padded to fixed maximum sizes, which lets
// any instance configuration share one function:
//   up to RF_MAX_WR write ports
//   addresses up to RF_MAX_AW bits (DEPTH <= 65536)
//   data up to RF_MAX_DW bits
// Callers zero-pad unused ports, address bits and data bits.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 64;

  localparam int RF_MAX_WR = 2;
  localparam int RF_MAX_AW = 16;
  localparam int RF_MAX_DW = 64;

  typedef struct packed {
    logic                 hit;
    logic [RF_MAX_DW-1:0] data;
  } rf_wr_t;

  // Ports are scanned in ascending order, so the highest-index matching
  // port wins a same-address conflict. With zero_reg set, address 0 never
  // reports a hit: register 0 is never written and never bypassed.
  function automatic rf_wr_t rf_resolve_write(
    input logic [RF_MAX_WR-1:0]                we,
    input logic [RF_MAX_WR-1:0][RF_MAX_AW-1:0] wa,
    input logic [RF_MAX_WR-1:0][RF_MAX_DW-1:0] wd,
    input logic [RF_MAX_AW-1:0]                addr,
    input logic                                zero_reg
  );
    rf_wr_t r;
    r = '0;
    for (int i = 0; i < RF_MAX_WR; i++) begin
      if (we[i] && (wa[i] == addr)) begin
        r.hit  = 1'b1;
        r.data = wd[i];
      end
    end
    if (zero_reg && (addr == '0)) begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset (clears rd)
//   re        read enable; when low rd holds its previous value
//   ra        read address
//   byp_hit   a write port targets ra this cycle
//   byp_data  winning write data for ra (valid when byp_hit)
//   mem_data  current stored content of regs[ra]
//   rd        registered read data, 1-cycle latency from ra
//
// Write-first: a same-cycle write to ra is forwarded instead of the stale
// stored value. With ZERO_REG the address-0 mask is applied last so that
// neither storage nor bypass can leak a nonzero value.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  input  logic              byp_hit,
  input  logic [DATA_W-1:0] byp_data,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] rd_next;

  always_comb begin
    rd_next = mem_data;
    if (byp_hit) begin
      rd_next = byp_data;
    end
    if ((ZERO_REG != 0) && (ra == '0)) begin
      rd_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
    end else if (re) begin
      rd <= rd_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
//
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset; clears every register and every rd,
//        and discards any writes/reads presented in that cycle
//   we   [NUM_WR]            per-port write enable
//   wa   [NUM_WR][ADDR_W]    write addresses
//   wd   [NUM_WR][DATA_W]    write data
//   re   [NUM_RD]            per-port read enable (0 = hold rd)
//   ra   [NUM_RD][ADDR_W]    read addresses
//   rd   [NUM_RD][DATA_W]    registered read data, 1-cycle latency
//
// Same-address write conflicts resolve to the highest-index port. Reads are
// write-first. With ZERO_REG=1 register 0 is read-only zero.
// Supports NUM_WR <= 2, DEPTH <= 65536, DATA_W <= 64.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 2,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WR-1:0]              we,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wa,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wd,
  input  logic [NUM_RD-1:0]              re,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  ra,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd
);

  logic [DATA_W-1:0] regs [DEPTH];

  // Write ports zero-padded to the helper's fixed sizes.
  logic [RF_MAX_WR-1:0]                we_p;
  logic [RF_MAX_WR-1:0][RF_MAX_AW-1:0] wa_p;
  logic [RF_MAX_WR-1:0][RF_MAX_DW-1:0] wd_p;

  always_comb begin
    we_p = '0;
    wa_p = '0;
    wd_p = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      we_p[i]             = we[i];
      wa_p[i][ADDR_W-1:0] = wa[i];
      wd_p[i][DATA_W-1:0] = wd[i];
    end
  end

  // Per-register write decision.
  logic [DEPTH-1:0]                wr_hit;
  logic [DEPTH-1:0][RF_MAX_DW-1:0] wr_full;

  always_comb begin
    rf_wr_t res;
    wr_hit  = '0;
    wr_full = '0;
    for (int r = 0; r < DEPTH; r++) begin
      res        = rf_resolve_write(we_p, wa_p, wd_p, RF_MAX_AW'(r), ZERO_REG != 0);
      wr_hit[r]  = res.hit;
      wr_full[r] = res.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_full[r][DATA_W-1:0];
        end
      end
    end
  end

  // Per-read-port bypass lookup and stored-value fetch.
  logic [NUM_RD-1:0]                byp_hit;
  logic [NUM_RD-1:0][RF_MAX_DW-1:0] byp_full;
  logic [DATA_W-1:0]                mem_rd [NUM_RD];

  always_comb begin
    rf_wr_t res;
    byp_hit  = '0;
    byp_full = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      res         = rf_resolve_write(we_p, wa_p, wd_p, RF_MAX_AW'(ra[j]), ZERO_REG != 0);
      byp_hit[j]  = res.hit;
      byp_full[j] = res.data;
      mem_rd[j]   = regs[ra[j]];
    end
  end

  // Padding bits above DATA_W carry nothing; fold them here so they are
  // consumed somewhere.
  logic unused_hi;
  assign unused_hi = ^{wr_full, byp_full};

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .re       (re[j]),
      .ra       (ra[j]),
      .byp_hit  (byp_hit[j]),
      .byp_data (byp_full[j][DATA_W-1:0]),
      .mem_data (mem_rd[j]),
      .rd       (rd[j])
    );
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file. Successor to the 64x32 single-write, dual-read register file in the CPU datapath. Adds:
- configurable width, depth, and read/write port counts
- per-port read enable for pipeline stalls
- same-cycle write-to-read bypass
- optional hardwired zero register
Sits between decode (read addresses) and writeback (write ports); read data is registered, giving 1-cycle latency.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 64, number of registers; must be a power of 2, at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- NUM_RD, 2, number of read ports, 1..4.
- NUM_WR, 2, number of write ports, 1..2.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- we  in  NUM_WR  per-port write enable.
- wa  in  NUM_WR x ADDR_W  write addresses (packed array).
- wd  in  NUM_WR x DATA_W  write data.
- re  in  NUM_RD  per-port read enable; 0 holds rd.
- ra  in  NUM_RD x ADDR_W  read addresses.
- rd  out  NUM_RD x DATA_W  registered read data.

Behaviour:
- Reset (rst=1 at posedge): all DEPTH registers clear to 0; all rd clear to 0. Writes and reads that cycle are ignored. Reset mid-stream discards pending writes.
- Write: at posedge with we[i]=1, regs[wa[i]] <= wd[i].
- Write conflict: two ports writing the same address in one cycle resolve to the highest-index port. Different addresses both commit.
- ZERO_REG=1:
  - writes to address 0 are dropped
  - reads of address 0 return 0, including via bypass
  - register 0 storage stays 0 regardless of we
- Read: at posedge with re[j]=1, rd[j] <= value of regs[ra[j]] after this cycle's writes (write-first).
  - If any enabled write port targets ra[j] this cycle, rd[j] takes the winning wd, not the old content.
  - Latency is 1 cycle from ra to rd.
- Read enable low: rd[j] holds its previous value (stall), even if the register it was read from is written later. There is no retroactive update.
- Out-of-range: none, since DEPTH is a power of 2 and every address is valid.
- All ports operate independently in the same cycle. There is no back-pressure and no busy signal.
- Storage is inferable as distributed RAM/flops; no reset-time loop over cycles is required.

Decomposition:
- Package regfile_pkg holds:
  - default constants RF_DATA_W=32, RF_DEPTH=64
  - function rf_resolve_write(we, wa, wd, addr) returning {hit, data} with highest-index priority and zero-register masking, shared by the write and bypass logic
- One natural sub-module, regfile_rd_port, instantiated NUM_RD times via generate. It holds the registered rd, the re hold mux, the bypass mux and the zero mask.

Test Plan:
- Reset clear: write 0xDEADBEEF to reg 5, pulse rst, read reg 5 -> rd=0 one cycle later; rd during and after reset = 0.
- Basic latency: write 0x12345678 to reg 10 on port 0; next cycle re[0]=1, ra[0]=10 -> rd[0]=0x12345678 exactly one cycle after the ra presentation.
- Bypass: same cycle we[1]=1, wa[1]=7, wd[1]=0xA5A5A5A5, and re[0]=re[1]=1, ra=7 -> both rd=0xA5A5A5A5 next cycle.
- Write conflict: port 0 writes 0x1111 and port 1 writes 0x2222 to reg 3 in the same cycle -> bypass read returns 0x2222; later read of reg 3 also returns 0x2222.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to reg 0 with a simultaneous read of reg 0 -> rd=0, and a later read = 0. With ZERO_REG=0 the same sequence returns 0xFFFFFFFF.
- Stall hold: read reg 4 (=0x44) with re=1, then re=0 for 3 cycles while reg 4 is written 0x55 and ra changes -> rd stays 0x44; re=1 -> rd=0x55 next cycle.
